vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter HTOTAL, default 800, pixel clocks per line.
REQ-002 Parameter HSYNC, default 96, hsync pulse width in pixels.
REQ-003 Parameter hbp, default 144, end of horizontal back porch (first active pixel).
REQ-004 Parameter hfp, default 784, beginning of horizontal front porch (first inactive pixel).
REQ-005 Parameter VTOTAL, default 521, lines per frame.
REQ-006 Parameter VSYNC, default 2, vsync pulse width in lines.
REQ-007 Parameter vbp, default 31, end of vertical back porch (first active line).
REQ-008 Parameter vfp, default 511, beginning of vertical front porch (first inactive line).
REQ-009 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-010 i_rst  input  1  reset; synchronous, active-high.
REQ-011 i_en  input  1  pixel enable; counters advance only in cycles where high.
REQ-012 i_vblank_ack  input  1  game-logic acknowledge of vblank request.
REQ-013 o_hc  output  10  horizontal counter, drives pattern/game pixel logic.
REQ-014 o_vc  output  10  vertical counter.
REQ-015 o_hsync  output  1  horizontal sync, active low.
REQ-016 o_vsync  output  1  vertical sync, active low.
REQ-017 o_active  output  1  high when (o_hc, o_vc) lies in active video.
REQ-018 o_frame_start  output  1  single-i_clk pulse at start of each frame.
REQ-019 o_vblank_req  output  1  level request: safe window for game state update.
REQ-020 o_overrun  output  1  sticky: a vblank request went unacknowledged for a whole frame.
REQ-021 o_frame_cnt  output  8  frame counter, wraps.

Function
REQ-022 In an i_en=1 cycle, o_hc SHALL increment; at HTOTAL-1 it wraps to 0 and o_vc increments; o_vc at VTOTAL-1 wraps to 0 on that same edge.
REQ-023 With i_en=0, o_hc, o_vc, o_hsync, o_vsync, o_active SHALL hold.
REQ-024 All outputs SHALL be registered; o_hsync, o_vsync, o_active SHALL be computed from next-counter values so they align with o_hc/o_vc in the same cycle (zero relative latency).
REQ-025 o_hsync SHALL be 0 iff o_hc < HSYNC; o_vsync SHALL be 0 iff o_vc < VSYNC.
REQ-026 o_active SHALL be 1 iff hbp <= o_hc < hfp and vbp <= o_vc < vfp.
REQ-027 o_frame_start SHALL be high for exactly one i_clk, in the cycle the counters first show (0,0) after wrapping from (HTOTAL-1, VTOTAL-1); it SHALL not repeat during following i_en=0 cycles.
REQ-028 o_frame_cnt SHALL increment on each o_frame_start, wrapping 255 -> 0.
REQ-029 Vblank request FSM states IDLE and PEND: IDLE -> PEND when counters reach (0, vfp); PEND -> IDLE on the edge after i_vblank_ack=1 is sampled.
REQ-030 o_vblank_req SHALL be 1 exactly in PEND.
REQ-031 i_vblank_ack in IDLE SHALL be ignored.
REQ-032 Ack sampled in the same cycle as a new (0, vfp) event: request set wins, FSM remains PEND.
REQ-033 Reaching (0, vfp) while already PEND SHALL set o_overrun; FSM stays PEND; o_overrun clears only on reset.
REQ-034 Counter comparisons SHALL be unsigned 10-bit; parameters require HSYNC<=hbp<hfp<=HTOTAL<=1024 and VSYNC<=vbp<vfp<=VTOTAL<=1024.

Reset
REQ-035 While i_rst=1, at each edge: o_hc=0, o_vc=0, o_hsync=0, o_vsync=0, o_active=0, o_frame_start=0, o_vblank_req=0 (IDLE), o_overrun=0, o_frame_cnt=0; reset overrides i_en.
REQ-036 Reset asserted mid-frame or mid-PEND SHALL take effect on the next edge; the first cycle after release SHALL show (0,0) with no o_frame_start pulse.

Structure
REQ-037 VGA 640x480 timing constants (HTOTAL, HSYNC, hbp, hfp, VTOTAL, VSYNC, vbp, vfp) SHALL live in a shared package/include used by this block and the pixel pattern logic.
REQ-038 One sub-module, vga_counter (parameterised wrap counter with enable and wrap flag), SHALL be instantiated twice (horizontal, vertical).

Verification
REQ-039 Reset then i_en=1 constant: o_hsync low for hc 0..95, high at 96; o_hc wraps 799 -> 0 and o_vc 0 -> 1 on the same edge.
REQ-040 Run one full frame: o_active high for exactly 640x480 = 307200 enabled cycles; o_vsync low only for vc 0..1; o_frame_start one pulse at (0,0), o_frame_cnt 0 -> 1.
REQ-041 i_en toggled 1/0 alternating: counters advance every second clock; o_frame_start still exactly one i_clk wide.
REQ-042 At (0,511) o_vblank_req rises; i_vblank_ack pulsed at vc=515: req low next cycle; o_overrun stays 0.
REQ-043 No ack for a full frame: at next (0,511) o_overrun=1, req stays 1; subsequent ack clears req but not o_overrun.
REQ-044 Assert i_rst for 1 cycle at (400,300) in PEND: next cycle all outputs at reset values; 256 frames later o_frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480 VGA timing constants and helpers
package vga_timing_pkg;

  localparam int unsigned CNT_W      = 10;

  localparam int unsigned VGA_HTOTAL = 800;
  localparam int unsigned VGA_HSYNC  = 96;
  localparam int unsigned VGA_HBP    = 144;
  localparam int unsigned VGA_HFP    = 784;
  localparam int unsigned VGA_VTOTAL = 521;
  localparam int unsigned VGA_VSYNC  = 2;
  localparam int unsigned VGA_VBP    = 31;
  localparam int unsigned VGA_VFP    = 511;

  typedef enum logic {
    VB_IDLE = 1'b0,
    VB_PEND = 1'b1
  } vblank_state_t;

  // Half-open window test lo <= v < hi on unsigned counter values
  function automatic logic in_window(logic [CNT_W-1:0] v,
                                     logic [CNT_W-1:0] lo,
                                     logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// rtl/vga_counter.sv - enabled wrap counter exposing its next value and wrap flag
module vga_counter #(
  parameter int unsigned MAX = 800,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // wrap is the advance that takes the count from LAST back to zero
  assign wrap = en && (count == LAST);

  // Next value is exported so the parent can register decodes in step with the count
  always_comb begin
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (en)
      count_next = count + W'(1);
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA sync/active generator with frame counter and vblank handshake
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned HTOTAL = VGA_HTOTAL,
  parameter int unsigned HSYNC  = VGA_HSYNC,
  parameter int unsigned hbp    = VGA_HBP,
  parameter int unsigned hfp    = VGA_HFP,
  parameter int unsigned VTOTAL = VGA_VTOTAL,
  parameter int unsigned VSYNC  = VGA_VSYNC,
  parameter int unsigned vbp    = VGA_VBP,
  parameter int unsigned vfp    = VGA_VFP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_vblank_ack,
  output logic [CNT_W-1:0] o_hc,
  output logic [CNT_W-1:0] o_vc,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic             o_frame_start,
  output logic             o_vblank_req,
  output logic             o_overrun,
  output logic [7:0]       o_frame_cnt
);

  localparam logic [CNT_W-1:0] HS_L  = CNT_W'(HSYNC);
  localparam logic [CNT_W-1:0] HBP_L = CNT_W'(hbp);
  localparam logic [CNT_W-1:0] HFP_L = CNT_W'(hfp);
  localparam logic [CNT_W-1:0] VS_L  = CNT_W'(VSYNC);
  localparam logic [CNT_W-1:0] VBP_L = CNT_W'(vbp);
  localparam logic [CNT_W-1:0] VFP_L = CNT_W'(vfp);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             vfp_hit;
  vblank_state_t    state;

  vga_counter #(.MAX(HTOTAL), .W(CNT_W)) u_hcnt (
    .clk        (i_clk),
    .rst        (i_rst),
    .en         (i_en),
    .count      (o_hc),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  vga_counter #(.MAX(VTOTAL), .W(CNT_W)) u_vcnt (
    .clk        (i_clk),
    .rst        (i_rst),
    .en         (h_wrap),
    .count      (o_vc),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Only the advance onto (0, vfp) counts; idling there with i_en low does not retrigger
  assign vfp_hit = h_wrap && (v_next == VFP_L);

  // Sync and active decoded from next counts so they line up with o_hc/o_vc
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_active <= 1'b0;
    end else begin
      o_hsync  <= (h_next >= HS_L);
      o_vsync  <= (v_next >= VS_L);
      o_active <= in_window(h_next, HBP_L, HFP_L) && in_window(v_next, VBP_L, VFP_L);
    end
  end

  // Frame pulse on the wrap into (0,0) and the free-running frame count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_start <= 1'b0;
      o_frame_cnt   <= 8'd0;
    end else begin
      o_frame_start <= v_wrap;
      o_frame_cnt   <= o_frame_cnt + {7'd0, v_wrap};
    end
  end

  // Vblank request handshake; a new request outranks a same-cycle ack
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= VB_IDLE;
      o_vblank_req <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      case (state)
        VB_IDLE: begin
          if (vfp_hit) begin
            state        <= VB_PEND;
            o_vblank_req <= 1'b1;
          end
        end
        VB_PEND: begin
          if (vfp_hit) begin
            o_overrun <= 1'b1;
          end else if (i_vblank_ack) begin
            state        <= VB_IDLE;
            o_vblank_req <= 1'b0;
          end
        end
        default: begin
          state        <= VB_IDLE;
          o_vblank_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
